// File: rtl/life_scan_control.sv
// -----------------------------------------------------------------------------
// life_scan_control
// Scan sequencer for the Game of Life update engine. The cell grid is held in
// nine banked memories with a 3x3 interleave:
//   bank    = (y mod 3)*3 + (x mod 3)
//   address = (y/3)*WIDTH_BLOCKS + x/3
// Each non-stalled SCAN cycle issues the nine neighbour reads for one cell.
// PIPE_DELAY advancing cycles later, the next state of that cell is written.
// The sequencer runs a requested number of generations. The read buffer
// flips after each generation (ping-pong frames).
//
// Ports
//   clk                 rising-edge clock
//   resetn              asynchronous active-low reset
//   start               begin a run (only looked at while idle)
//   wrap_mode           0 = dead border, 1 = toroidal (latched with start)
//   gen_count           generations to run (latched with start)
//   stall               freeze scan and pipeline for this cycle
//   busy                high from accepted start through the done cycle
//   done                one-cycle pulse at the end of a run
//   read_enable         per-bank neighbour read strobe
//   read_addr           per-bank read address, bank b at [b*ADDR_WIDTH +: ADDR_WIDTH]
//   data_valid          neighbour data present at the memory outputs
//   write_enable        one-hot next-state write strobe
//   write_addr          write address shared by all banks
//   frame_buffer_select buffer being read; writes target the other one
// -----------------------------------------------------------------------------
module life_scan_control #(
    parameter int WIDTH_BLOCKS  = 4,
    parameter int HEIGHT_BLOCKS = 4,
    parameter int ADDR_WIDTH    = 4,
    parameter int GEN_WIDTH     = 16,
    parameter int READ_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    wrap_mode,
    input  logic [GEN_WIDTH-1:0]    gen_count,
    input  logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic [8:0]              read_enable,
    output logic [9*ADDR_WIDTH-1:0] read_addr,
    output logic                    data_valid,
    output logic [8:0]              write_enable,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic                    frame_buffer_select
);
    localparam int PIPE_DELAY = READ_LATENCY + 1;
    localparam int DRAIN_W    = $clog2(PIPE_DELAY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_XB    = ADDR_WIDTH'(WIDTH_BLOCKS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_YB    = ADDR_WIDTH'(HEIGHT_BLOCKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(WIDTH_BLOCKS);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    // One neighbour coordinate along one axis: in range, position within its
    // 3-cell block (selects the bank), and block index (forms the address).
    typedef struct packed {
        logic                  ok;
        logic [1:0]            m;
        logic [ADDR_WIDTH-1:0] b;
    } axis_t;

    state_t                 r_state, w_next_state;
    logic                   r_wrap;
    logic [GEN_WIDTH-1:0]   r_gen_target, r_gen;
    logic [DRAIN_W-1:0]     r_drain;
    logic                   r_frame;

    // The current cell is kept as (block, position-in-block) per axis.
    // Neighbour banks and addresses then follow without any divide by 3.
    logic [1:0]             r_xm, r_ym;
    logic [ADDR_WIDTH-1:0]  r_xb, r_yb;

    logic [PIPE_DELAY-1:0]  r_pv;
    logic [3:0]             r_pbank [PIPE_DELAY];
    logic [ADDR_WIDTH-1:0]  r_paddr [PIPE_DELAY];

    logic                   w_issue, w_last_col, w_last_row, w_drain_last, w_gen_last;
    logic [3:0]             w_own_bank;
    logic [ADDR_WIDTH-1:0]  w_own_addr;
    axis_t                  w_col [3];
    axis_t                  w_row [3];

    // Step one axis by dir (0 = -1, 1 = 0, 2 = +1). Past the edge, the result
    // wraps to the far side. It is flagged out of range unless wrapping is on.
    function automatic axis_t stepAxis(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] b,
                                       input logic [ADDR_WIDTH-1:0] last, input logic wrap,
                                       input logic [1:0] dir);
        axis_t r;
        r.ok = 1'b1;
        r.m  = m;
        r.b  = b;
        if (dir == 2'd0) begin
            if (m != 2'd0) begin
                r.m = m - 2'd1;
            end else begin
                r.m = 2'd2;
                if (b != '0) begin
                    r.b = b - ADDR_WIDTH'(1);
                end else begin
                    r.b  = last;
                    r.ok = wrap;
                end
            end
        end else if (dir == 2'd2) begin
            if (m != 2'd2) begin
                r.m = m + 2'd1;
            end else begin
                r.m = 2'd0;
                if (b != last) begin
                    r.b = b + ADDR_WIDTH'(1);
                end else begin
                    r.b  = '0;
                    r.ok = wrap;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = (r_state == SCAN) && !stall;
        w_last_col   = (r_xm == 2'd2) && (r_xb == LAST_XB);
        w_last_row   = (r_ym == 2'd2) && (r_yb == LAST_YB);
        w_drain_last = (r_drain == DRAIN_W'(PIPE_DELAY - 1));
        w_gen_last   = ((r_gen + GEN_WIDTH'(1)) == r_gen_target);
        case (r_state)
            IDLE:    if (start) w_next_state = (gen_count != '0) ? SCAN : FINISH;
            SCAN:    if (!stall && w_last_col && w_last_row) w_next_state = DRAIN;
            DRAIN:   if (!stall && w_drain_last) w_next_state = w_gen_last ? FINISH : SCAN;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Run bookkeeping and the raster position. x runs fastest. A new
    // generation always restarts at (0,0). DRAIN waits only for the
    // pipeline to empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrap       <= 1'b0;
            r_gen_target <= '0;
            r_gen        <= '0;
            r_drain      <= '0;
            r_frame      <= 1'b0;
            r_xm         <= '0;
            r_xb         <= '0;
            r_ym         <= '0;
            r_yb         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wrap       <= wrap_mode;
                        r_gen_target <= gen_count;
                        r_gen        <= '0;
                        r_drain      <= '0;
                        r_xm         <= '0;
                        r_xb         <= '0;
                        r_ym         <= '0;
                        r_yb         <= '0;
                    end
                end
                SCAN: begin
                    if (!stall) begin
                        if (r_xm != 2'd2) begin
                            r_xm <= r_xm + 2'd1;
                        end else begin
                            r_xm <= '0;
                            if (r_xb != LAST_XB) begin
                                r_xb <= r_xb + ADDR_WIDTH'(1);
                            end else begin
                                r_xb <= '0;
                                if (r_ym != 2'd2) begin
                                    r_ym <= r_ym + 2'd1;
                                end else begin
                                    r_ym <= '0;
                                    r_yb <= r_yb + ADDR_WIDTH'(1);
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (w_drain_last) begin
                            r_frame <= !r_frame;
                            r_gen   <= r_gen + GEN_WIDTH'(1);
                            r_drain <= '0;
                            r_xm    <= '0;
                            r_xb    <= '0;
                            r_ym    <= '0;
                            r_yb    <= '0;
                        end else begin
                            r_drain <= r_drain + DRAIN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_own_bank = ({2'b00, r_ym} * 4'd3) + {2'b00, r_xm};
        w_own_addr = (r_yb * ROW_STRIDE) + r_xb;
        for (int d = 0; d < 3; d++) begin
            w_col[d] = stepAxis(r_xm, r_xb, LAST_XB, r_wrap, 2'(d));
            w_row[d] = stepAxis(r_ym, r_yb, LAST_YB, r_wrap, 2'(d));
        end
    end

    // The three row offsets land on three different row-banks. The same holds
    // for columns. So each bank matches exactly one (dy,dx) neighbour.
    always_comb begin
        read_enable = '0;
        read_addr   = '0;
        if (w_issue) begin
            for (int b = 0; b < 9; b++) begin
                for (int dy = 0; dy < 3; dy++) begin
                    for (int dx = 0; dx < 3; dx++) begin
                        if (w_row[dy].ok && w_col[dx].ok &&
                            (w_row[dy].m == 2'(b / 3)) && (w_col[dx].m == 2'(b % 3))) begin
                            read_enable[b] = 1'b1;
                            read_addr[b*ADDR_WIDTH +: ADDR_WIDTH] = (w_row[dy].b * ROW_STRIDE) + w_col[dx].b;
                        end
                    end
                end
            end
        end
    end

    // Issue pipeline: stage i holds the cell issued i+1 advancing cycles ago.
    // A stall freezes every stage, so the memories see a consistent picture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pv <= '0;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_pbank[i] <= '0;
                r_paddr[i] <= '0;
            end
        end else if (!stall) begin
            r_pv[0]    <= w_issue;
            r_pbank[0] <= w_own_bank;
            r_paddr[0] <= w_own_addr;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_pbank[i] <= r_pbank[i-1];
                r_paddr[i] <= r_paddr[i-1];
            end
        end
    end

    always_comb begin
        write_enable = '0;
        write_addr   = '0;
        if (r_pv[PIPE_DELAY-1] && !stall) begin
            write_enable = 9'(1) << r_pbank[PIPE_DELAY-1];
            write_addr   = r_paddr[PIPE_DELAY-1];
        end
    end

    assign data_valid          = r_pv[READ_LATENCY-1] && !stall;
    assign busy                = (r_state != IDLE);
    assign done                = (r_state == FINISH);
    assign frame_buffer_select = r_frame;

endmodule

// File: tb/tb_life_scan_control.sv
// -----------------------------------------------------------------------------
// tb_life_scan_control
// Self-checking bench for life_scan_control on a 6x6 grid (2x2 blocks).
// A cycle-level behavioural model tracks the raster as a linear cell index.
// It derives neighbour reads with plain integer arithmetic. Issued cells sit
// in a queue tagged by their advancing-cycle number. Literal expectations
// pin the model on hand-worked cells, latencies and frame parity.
// -----------------------------------------------------------------------------
module tb_life_scan_control;
    localparam int WB    = 2;
    localparam int HB    = 2;
    localparam int AW    = 4;
    localparam int GW    = 16;
    localparam int RL    = 1;
    localparam int PD    = RL + 1;
    localparam int W     = 3 * WB;
    localparam int H     = 3 * HB;
    localparam int NCELL = W * H;
    localparam int NADDR = WB * HB;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic            start = 1'b0;
    logic            wrap_mode = 1'b0;
    logic            stall = 1'b0;
    logic [GW-1:0]   gen_count = '0;
    logic            busy, done, data_valid, frame_buffer_select;
    logic [8:0]      read_enable, write_enable;
    logic [9*AW-1:0] read_addr;
    logic [AW-1:0]   write_addr;

    int errors = 0;
    int checks = 0;

    life_scan_control #(
        .WIDTH_BLOCKS (WB),
        .HEIGHT_BLOCKS(HB),
        .ADDR_WIDTH   (AW),
        .GEN_WIDTH    (GW),
        .READ_LATENCY (RL)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .start              (start),
        .wrap_mode          (wrap_mode),
        .gen_count          (gen_count),
        .stall              (stall),
        .busy               (busy),
        .done               (done),
        .read_enable        (read_enable),
        .read_addr          (read_addr),
        .data_valid         (data_valid),
        .write_enable       (write_enable),
        .write_addr         (write_addr),
        .frame_buffer_select(frame_buffer_select)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Neighbour reads for linear cell index pos, straight from the grid rules
    function automatic void modelReads(input int pos, input bit wrapOn,
                                       output logic [8:0] en, output logic [9*AW-1:0] ad);
        int x, y, nx, ny, bank;
        x  = pos % W;
        y  = pos / W;
        en = '0;
        ad = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                if (wrapOn) begin
                    nx = (nx + W) % W;
                    ny = (ny + H) % H;
                end
                if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
                    bank = (ny % 3) * 3 + (nx % 3);
                    en[bank] = 1'b1;
                    ad[bank*AW +: AW] = AW'((ny / 3) * WB + (nx / 3));
                end
            end
        end
    endfunction

    typedef struct {
        int idx;
        int bank;
        int addr;
    } issue_t;

    issue_t pipeQ[$];
    bit     mActive, mFinish, mWrap, mFrame;
    int     mPos, mDrain, mGen, mTarget, mAdv;
    int     cov [9][NADDR];

    // Compare DUT outputs with the model on every falling edge, then advance
    // the model with the inputs the DUT will sample at the next rising edge
    always @(negedge clk) begin : compareModel
        logic [8:0]      expEn, expWe;
        logic [9*AW-1:0] expAd;
        logic [AW-1:0]   expWa;
        bit              expDv, covOk;
        issue_t          rec;
        if (!resetn) begin
            checkOutput("reset busy", busy, 0);
            checkOutput("reset done", done, 0);
            checkOutput("reset read_enable", read_enable, 0);
            checkOutput("reset read_addr", read_addr, 0);
            checkOutput("reset data_valid", data_valid, 0);
            checkOutput("reset write_enable", write_enable, 0);
            checkOutput("reset write_addr", write_addr, 0);
            checkOutput("reset frame", frame_buffer_select, 0);
            mActive = 0; mFinish = 0; mFrame = 0; mAdv = 0;
            pipeQ.delete();
            foreach (cov[b, a]) cov[b][a] = 0;
        end else begin
            expEn = '0; expAd = '0; expWe = '0; expWa = '0; expDv = 0;
            if (mActive && mPos < NCELL && !stall) modelReads(mPos, mWrap, expEn, expAd);
            if (!stall) begin
                foreach (pipeQ[i]) begin
                    if (pipeQ[i].idx == mAdv - RL) expDv = 1;
                    if (pipeQ[i].idx == mAdv - PD) begin
                        expWe[pipeQ[i].bank] = 1'b1;
                        expWa = AW'(pipeQ[i].addr);
                    end
                end
            end
            checkOutput("busy", busy, mActive || mFinish);
            checkOutput("done", done, mFinish);
            checkOutput("read_enable", read_enable, expEn);
            checkOutput("read_addr", read_addr, expAd);
            checkOutput("data_valid", data_valid, expDv);
            checkOutput("write_enable", write_enable, expWe);
            checkOutput("write_addr", write_addr, expWa);
            checkOutput("frame_buffer_select", frame_buffer_select, mFrame);

            if ($countones(write_enable) == 1 && int'(write_addr) < NADDR) begin
                for (int b = 0; b < 9; b++) if (write_enable[b]) cov[b][int'(write_addr)]++;
            end

            if (mFinish) begin
                mFinish = 0;
            end else if (!mActive) begin
                if (start) begin
                    if (gen_count != '0) begin
                        mActive = 1; mPos = 0; mDrain = 0; mGen = 0;
                        mTarget = int'(gen_count);
                        mWrap   = wrap_mode;
                        foreach (cov[b, a]) cov[b][a] = 0;
                    end else begin
                        mFinish = 1;
                    end
                end
            end else if (!stall) begin
                if (mPos < NCELL) begin
                    rec.idx  = mAdv;
                    rec.bank = ((mPos / W) % 3) * 3 + (mPos % W) % 3;
                    rec.addr = ((mPos / W) / 3) * WB + (mPos % W) / 3;
                    pipeQ.push_back(rec);
                    mPos++;
                end else begin
                    mDrain++;
                    if (mDrain == PD) begin
                        covOk = 1;
                        foreach (cov[b, a]) if (cov[b][a] != 1) covOk = 0;
                        checkOutput("each bank address written once per generation", covOk, 1);
                        foreach (cov[b, a]) cov[b][a] = 0;
                        mFrame = ~mFrame;
                        mGen++;
                        if (mGen == mTarget) begin
                            mActive = 0;
                            mFinish = 1;
                        end else begin
                            mPos = 0;
                            mDrain = 0;
                        end
                    end
                end
            end
            if (!stall) begin
                mAdv++;
                while (pipeQ.size() > 0 && pipeQ[0].idx < mAdv - PD) void'(pipeQ.pop_front());
            end
        end
    end

    // Start a run and wait for done. lat is the number of edges from the
    // accept edge to the done cycle. stallMode: 0 none, 1 fixed, 2 random.
    // Every call begins and ends just after a rising edge.
    task automatic applyStimulus(input int n, input bit w, input int stallMode,
                                 output int lat, output int nStall);
        bit got;
        gen_count = GW'(n);
        wrap_mode = w;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        wrap_mode = ~w;
        gen_count = GW'($urandom_range(1, 5));
        got = 0; lat = -1; nStall = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            case (stallMode)
                1:       stall = (i inside {10, 11, 12, 39});
                2:       stall = ($urandom_range(0, 4) == 0);
                default: stall = 1'b0;
            endcase
            start = (i == 20);
            @(negedge clk);
            if (stallMode == 0 && n == 1 && !w) begin
                if (i == 0) begin
                    checkOutput("dead (0,0) read_enable", read_enable, 9'b000011011);
                    checkOutput("dead (0,0) read_addr", read_addr, 0);
                end
                if (i == 15) begin
                    checkOutput("dead (3,2) read_enable", read_enable, 9'h1FF);
                    checkOutput("dead (3,2) bank5 addr", read_addr[5*AW +: AW], 0);
                    checkOutput("dead (3,2) bank1 addr", read_addr[1*AW +: AW], 3);
                end
                if (i == 17) begin
                    checkOutput("(3,2) write_enable", write_enable, 9'h040);
                    checkOutput("(3,2) write_addr", write_addr, 1);
                end
            end
            if (stallMode == 0 && n == 1 && w && i == 0) begin
                checkOutput("wrap (0,0) read_enable", read_enable, 9'h1FF);
                checkOutput("wrap (0,0) bank8 addr", read_addr[8*AW +: AW], 3);
                checkOutput("wrap (0,0) bank2 addr", read_addr[2*AW +: AW], 1);
                checkOutput("wrap (0,0) bank6 addr", read_addr[6*AW +: AW], 2);
            end
            if (done) begin
                got = 1;
                lat = i;
            end else begin
                if (stall) nStall++;
                @(posedge clk); #1;
            end
        end
        if (!got) checkOutput("done seen before timeout", 0, 1);
        @(posedge clk); #1;
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic resetMidScan();
        gen_count = GW'(1);
        wrap_mode = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("busy before mid-scan reset", busy, 1);
        checkOutput("reads before mid-scan reset", read_enable, 9'h1FF);
        #1 resetn = 1'b0;
        #1;
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset read_enable", read_enable, 0);
        checkOutput("async reset read_addr", read_addr, 0);
        checkOutput("async reset write_enable", write_enable, 0);
        checkOutput("async reset data_valid", data_valid, 0);
        checkOutput("async reset done", done, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle busy after reset", busy, 0);
            checkOutput("idle reads after reset", read_enable, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int lat, ns, n;
        bit w, expFrame;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        expFrame = 0;

        resetMidScan();

        applyStimulus(2, 1'b0, 0, lat, ns);
        checkOutput("gen2 done latency", lat, 2 * (NCELL + PD));
        checkOutput("gen2 done latency literal", lat, 76);
        checkOutput("gen2 final frame", frame_buffer_select, 0);
        checkOutput("busy after done", busy, 0);

        applyStimulus(1, 1'b0, 0, lat, ns);
        checkOutput("gen1 dead latency", lat, 38);
        checkOutput("gen1 dead frame", frame_buffer_select, 1);

        applyStimulus(0, 1'b0, 0, lat, ns);
        checkOutput("gen0 latency", lat, 0);
        checkOutput("gen0 frame unchanged", frame_buffer_select, 1);

        applyStimulus(1, 1'b1, 0, lat, ns);
        checkOutput("gen1 wrap latency", lat, 38);
        checkOutput("gen1 wrap frame", frame_buffer_select, 0);

        applyStimulus(2, 1'b0, 1, lat, ns);
        checkOutput("stalled gen2 latency", lat, 80);
        checkOutput("stalled gen2 frame", frame_buffer_select, 0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            w = 1'($urandom_range(0, 1));
            applyStimulus(n, w, 2, lat, ns);
            expFrame ^= n[0];
            checkOutput("random run latency", lat, n * (NCELL + PD) + ns);
            checkOutput("random run frame", frame_buffer_select, expFrame);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
